aes_mixcol_stage: RTL
=====================

# aes_mixcol_stage

Column-serial AES MixColumns + AddRoundKey stage that registers a 128-bit round state, processes it one or more columns per cycle through a shared MixColumns unit, and presents the result on a valid/ready output. It sits directly upstream of the round-output timing cones. It is their launch register bank: the combinational cone logic consumes out_data bits, and each accepted block drives those bits exactly once.

## Interface
- NCOL, default 1: columns processed per beat; legal values 1, 2, 4; beats per block B = 4/NCOL.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  stage can accept a block this cycle.
- in_state  in  128  AES state; byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3, row 0 first.
- in_key  in  128  round key, same byte order.
- in_final  in  1  final round: skip MixColumns, apply AddRoundKey only.
- out_valid  out  1  result held on out_data.
- out_ready  in  1  downstream accepts result.
- out_data  out  128  MixColumns(state) XOR key, or state XOR key when final.

## Operation
- FSM states are IDLE, BUSY, DONE. Reset value is IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, the stage captures in_state, in_key and in_final, clears the beat counter and moves to BUSY.
- BUSY: in_ready=0. Each cycle, columns cnt*NCOL .. cnt*NCOL+NCOL-1 pass through MixColumns (or bypass if final), are XORed with the matching key columns, and are written into the result register. cnt increments. After beat B-1 the FSM moves to DONE.
- DONE: out_valid=1 and out_data is stable. On out_ready:
  - If in_valid is also high, in_ready=1 and the new block is captured the same cycle (FSM to BUSY), giving back-to-back operation.
  - Otherwise the FSM moves to IDLE.
- While DONE and out_ready=0: in_ready=0, and out_data and out_valid are held unchanged regardless of the inputs.
- MixColumns per column (a0..a3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
  - xtime(x) = (x<<1)[7:0] ^ (x[7] ? 8'h1b : 0); 3x = xtime(x)^x.
  - All arithmetic is 8-bit GF(2^8); no carries propagate between bytes.
- The beat counter is log2(B) bits wide (zero width when NCOL=4, i.e. a single beat). It is never observed outside the block.
- Columns not yet processed keep their stale result-register value. out_valid is never high while any column is stale.

## Timing
- Reset (rst_n=0 at an edge): FSM=IDLE, out_valid=0, out_data=128'h0, cnt=0.
  - in_ready reads 0 in any cycle where rst_n=0.
  - A block in BUSY or DONE is discarded without being emitted.
- Latency: a block accepted at edge t has out_valid=1 after edge t+B (NCOL=1: 4 cycles; NCOL=4: 1 cycle).
- Throughput with out_ready held high: one block per B+1 cycles (IDLE/handoff overlapped in DONE). Capture and emit happen on the same edge when in DONE with out_ready=1 and in_valid=1.
- Handshake rules:
  - A transfer occurs only when valid&ready are both high at an edge.
  - The source must keep in_valid, in_state and in_key stable until accepted.
  - in_final is sampled only at acceptance.
- Simultaneous out_ready and in_valid in DONE: the old result is consumed and the new block is captured on the same edge. out_valid drops to 0 the next cycle.
- Inputs changing in BUSY have no effect on the result.
- Registered outputs: out_valid and out_data. in_ready is combinational from FSM state, out_ready and rst_n only; it has no path from in_valid.

## Test plan
- Single column check: NCOL=1, key=0, final=0, all four columns = db 13 53 45. Required: after 4 cycles out_data = {8e 4d a1 bc} x4 and out_valid=1.
- FIPS-197 round check: state column 0 = d4 bf 5d 30, other columns 01 01 01 01, key=0. Required: column 0 = 04 66 81 e5, others 01 01 01 01. Repeat with NCOL=2 and NCOL=4: latency must be 2 and 1 cycles respectively.
- Final round: final=1, state=f2 0a 22 5c x4, key = 0xff in every byte. Required: out_data = 0d f5 dd a3 x4, with no MixColumns applied.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises while in_valid=1 with a new block. Required: out_data is unchanged, in_ready=0 throughout, and the new block is accepted on the out_ready edge. The next result appears B cycles later.
- Reset mid-block: drop rst_n for one cycle while in BUSY at beat 2. Required: out_valid=0, out_data=0 and in_ready=1 the cycle after release; no result is emitted for the aborted block.
- Streaming: 8 back-to-back blocks with out_ready=1. Required: results arrive in order, one per 5 cycles at NCOL=1, and every value matches the software model.

Source files
------------

// File: rtl/aes_mixcol_stage.sv
// Column-serial AES MixColumns + AddRoundKey stage with valid/ready handshakes.
// A captured block is processed NCOL columns per beat into the result register.
// The result register is then held on out_data until downstream accepts it.
module aes_mixcol_stage #(
  parameter int unsigned NCOL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_final,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned NBEAT = 4 / NCOL;
  // With a single beat the counter is logically zero-width; one spare bit keeps it declarable.
  localparam int unsigned CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     blk_q, blk_d;
  logic [127:0]     key_q, key_d;
  logic             fin_q, fin_d;
  logic [127:0]     res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ x3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ x3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ x3(a3),
            x3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Ready depends only on state, out_ready and reset, never on in_valid.
  assign in_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Next-state, beat processing and block capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    key_d   = key_q;
    fin_d   = fin_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_BUSY: begin
        for (int c = 0; c < 4; c++) begin
          if (CNT_W'(c / NCOL) == cnt_q) begin
            res_d[127-32*c -: 32] = (fin_q ? blk_q[127-32*c -: 32] : mix_col(blk_q[127-32*c -: 32]))
                                    ^ key_q[127-32*c -: 32];
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BEAT) state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Capture from IDLE, or from DONE in the same edge that hands off the old result.
    if (accept) begin
      blk_d   = in_state;
      key_d   = in_key;
      fin_d   = in_final;
      cnt_d   = '0;
      state_d = ST_BUSY;
    end

    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      fin_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      fin_q       <= fin_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = res_q;

endmodule
